main_memory_port_arbiter: RTL and testbench
===========================================

Name: main_memory_port_arbiter

Overview:
- Shares a single main-memory read/write port between two requesters: instruction fetch (PC side) and data access (load/store from the memory stage).
- Arbitration is per cycle with valid/ready request handshakes and one-cycle registered responses.
- Data has priority; a starvation limit guarantees fetch progress.
- A flush input discards fetch traffic on taken jumps.

Parameters:
- ADDR_WIDTH, 32, width of all memory addresses.
- DATA_WIDTH, 32, width of read/write data.
- STARVE_LIMIT, 3, max consecutive data grants while fetch waits (range 1..15).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- fetch_req_valid  input  1  fetch request present.
- fetch_req_addr  input  ADDR_WIDTH  fetch address (PC value).
- fetch_req_ready  output  1  fetch request accepted this cycle.
- fetch_resp_valid  output  1  fetch response valid.
- fetch_resp_data  output  DATA_WIDTH  fetched instruction word.
- data_req_valid  input  1  data request present.
- data_req_write  input  1  1 = store, 0 = load.
- data_req_addr  input  ADDR_WIDTH  load/store address.
- data_req_wdata  input  DATA_WIDTH  store data.
- data_req_ready  output  1  data request accepted this cycle.
- data_resp_valid  output  1  data response (load data or store ack).
- data_resp_data  output  DATA_WIDTH  load data; 0 for store ack.
- flush  input  1  cancel fetch traffic (taken jump).
- mem_read_address  output  ADDR_WIDTH  to memory read port (combinational read).
- mem_read_data  input  DATA_WIDTH  from memory read port.
- mem_write_address  output  ADDR_WIDTH  to memory write port.
- mem_write_data  output  DATA_WIDTH  to memory write port.
- mem_write_enable  output  1  memory write strobe, committed at posedge.
- starve_count  output  4  debug: current consecutive data-grant streak.

Behaviour:
- A transfer occurs in a cycle where valid & ready are both high. At most one grant per cycle. Ready is combinational from valids, flush, state and rst.
- While rst = 0, all readies and mem_write_enable are forced to 0.
- State machine with states PRIO_DATA (reset state) and PRIO_FETCH:
  - PRIO_DATA: data_req_valid wins. fetch_req_ready = fetch_req_valid & ~data_req_valid & ~flush.
  - PRIO_FETCH: fetch wins if fetch_req_valid & ~flush, otherwise data is granted.
  - PRIO_DATA -> PRIO_FETCH: when a data grant occurs with fetch_req_valid & ~flush and starve_count + 1 == STARVE_LIMIT.
  - PRIO_FETCH -> PRIO_DATA: on any fetch grant, or when fetch_req_valid = 0 or flush = 1.
- starve_count:
  - +1 on each data grant while fetch_req_valid & ~flush.
  - Clears to 0 on a fetch grant, or in any cycle with fetch_req_valid = 0 or flush = 1.
  - Never exceeds STARVE_LIMIT. Reset value 0.
- Memory drive:
  - mem_read_address = granted address (fetch_req_addr or data_req_addr); 0 when there is no grant.
  - Store grant: mem_write_enable = 1, mem_write_address = data_req_addr, mem_write_data = data_req_wdata. Otherwise all three are 0.
- Responses, latency exactly 1 cycle:
  - A grant in cycle T registers mem_read_data (or 0 for a store) and asserts the matching resp_valid in T+1 for one cycle only.
  - Responses cannot be backpressured.
  - resp_data holds its last value when resp_valid = 0.
- Back-to-back grants every cycle are allowed, giving full throughput.
- Read-after-write to the same address in consecutive cycles returns the new data, because the write commits at the T edge and the read in T+1 is combinational.
- Flush:
  - While flush = 1, no fetch grant is made.
  - fetch_resp_valid = registered_fetch_valid & ~flush, so a fetch response arriving in a flush cycle is dropped.
  - Data traffic is unaffected.
- Reset, synchronous:
  - Both resp_valids -> 0 and both resp_datas -> 0.
  - state -> PRIO_DATA, starve_count -> 0.
  - An in-flight response at reset is discarded.
- Simultaneous flush and data request: the data request is granted normally and starve_count clears.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with both valids high -> all readies 0, mem_write_enable 0, both resp_valid 0, starve_count 0. Release -> data granted first.
- Fetch only: fetch_req_valid = 1, addrs 0, 1, 2 on consecutive cycles, memory preloaded with 0xA0, 0xA1, 0xA2 -> fetch_req_ready = 1 each cycle; fetch_resp_data = 0xA0, 0xA1, 0xA2 one cycle later each.
- Starvation (STARVE_LIMIT = 3): both valid continuously -> grant order D, D, D, F, D, D, D, F; starve_count 1, 2, 3, 0, ...
- Store then load: store 0xDEADBEEF to addr 0x10 at T, load addr 0x10 at T+1 -> mem_write_enable = 1 at T; data_resp_valid with data 0 at T+1; data_resp_data = 0xDEADBEEF at T+2.
- Flush: fetch granted at T, flush = 1 at T+1 with fetch_req_valid = 1 -> fetch_resp_valid = 0 at T+1, fetch_req_ready = 0 at T+1; fetch resumes at T+2.
- Reset mid-operation: load granted at T, rst = 0 sampled at the T edge -> data_resp_valid stays 0 at T+1; no write strobe while rst = 0.

Source files
------------

// File: rtl/main_memory_port_arbiter.sv
// rtl/main_memory_port_arbiter.sv - two-requester main-memory port arbiter (data priority, fetch starvation guard)
module main_memory_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
    output logic                  fetch_req_ready,
    output logic                  fetch_resp_valid,
    output logic [DATA_WIDTH-1:0] fetch_resp_data,
    input  logic                  data_req_valid,
    input  logic                  data_req_write,
    input  logic [ADDR_WIDTH-1:0] data_req_addr,
    input  logic [DATA_WIDTH-1:0] data_req_wdata,
    output logic                  data_req_ready,
    output logic                  data_resp_valid,
    output logic [DATA_WIDTH-1:0] data_resp_data,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    output logic [3:0]            starve_count
);

    localparam logic [0:0] PRIO_DATA  = 1'b0;
    localparam logic [0:0] PRIO_FETCH = 1'b1;
    localparam logic [4:0] LIMIT      = 5'(STARVE_LIMIT);

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic                  fetch_eligible;
    logic                  fetch_grant;
    logic                  data_grant;
    logic                  data_store;
    logic                  streak_hit;
    logic [3:0]            starve_next;
    logic                  fetch_valid_q;
    logic                  data_valid_q;
    logic [DATA_WIDTH-1:0] fetch_data_q;
    logic [DATA_WIDTH-1:0] data_data_q;

    // A flushed fetch is treated as absent for arbitration and streak tracking.
    assign fetch_eligible = fetch_req_valid & ~flush;
    assign streak_hit     = ({1'b0, starve_count} + 5'd1) == LIMIT;

    always_comb begin
        fetch_grant = 1'b0;
        data_grant  = 1'b0;
        if (rst) begin
            if (state == PRIO_FETCH) begin
                fetch_grant = fetch_eligible;
                data_grant  = data_req_valid & ~fetch_eligible;
            end else begin
                data_grant  = data_req_valid;
                fetch_grant = fetch_eligible & ~data_req_valid;
            end
        end
    end

    assign fetch_req_ready = fetch_grant;
    assign data_req_ready  = data_grant;
    assign data_store      = data_grant & data_req_write;

    assign mem_read_address  = fetch_grant ? fetch_req_addr :
                               (data_grant ? data_req_addr : '0);
    assign mem_write_enable  = data_store;
    assign mem_write_address = data_store ? data_req_addr  : '0;
    assign mem_write_data    = data_store ? data_req_wdata : '0;

    always_comb begin
        starve_next = starve_count;
        if (!fetch_eligible || fetch_grant) begin
            starve_next = 4'd0;
        end else if (data_grant && ({1'b0, starve_count} != LIMIT)) begin
            starve_next = starve_count + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PRIO_DATA: begin
                if (data_grant && fetch_eligible && streak_hit) begin
                    state_next = PRIO_FETCH;
                end
            end
            PRIO_FETCH: begin
                if (fetch_grant || !fetch_eligible) begin
                    state_next = PRIO_DATA;
                end
            end
            default: state_next = PRIO_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= PRIO_DATA;
            starve_count  <= 4'd0;
            fetch_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            fetch_data_q  <= '0;
            data_data_q   <= '0;
        end else begin
            state         <= state_next;
            starve_count  <= starve_next;
            fetch_valid_q <= fetch_grant;
            data_valid_q  <= data_grant;
            if (fetch_grant) begin
                fetch_data_q <= mem_read_data;
            end
            if (data_grant) begin
                data_data_q <= data_req_write ? '0 : mem_read_data;
            end
        end
    end

    // A fetch response landing in a flush cycle belongs to the squashed path.
    assign fetch_resp_valid = fetch_valid_q & ~flush;
    assign fetch_resp_data  = fetch_data_q;
    assign data_resp_valid  = data_valid_q;
    assign data_resp_data   = data_data_q;

endmodule

// File: tb/tb_main_memory_port_arbiter.sv
// tb/tb_main_memory_port_arbiter.sv - directed self-checking bench for main_memory_port_arbiter
module tb_main_memory_port_arbiter;

    logic        clk;
    logic        rst;
    logic        fetch_req_valid;
    logic [31:0] fetch_req_addr;
    logic        fetch_req_ready;
    logic        fetch_resp_valid;
    logic [31:0] fetch_resp_data;
    logic        data_req_valid;
    logic        data_req_write;
    logic [31:0] data_req_addr;
    logic [31:0] data_req_wdata;
    logic        data_req_ready;
    logic        data_resp_valid;
    logic [31:0] data_resp_data;
    logic        flush;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [3:0]  starve_count;

    logic [31:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;

    main_memory_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_req_valid(fetch_req_valid),
        .fetch_req_addr(fetch_req_addr),
        .fetch_req_ready(fetch_req_ready),
        .fetch_resp_valid(fetch_resp_valid),
        .fetch_resp_data(fetch_resp_data),
        .data_req_valid(data_req_valid),
        .data_req_write(data_req_write),
        .data_req_addr(data_req_addr),
        .data_req_wdata(data_req_wdata),
        .data_req_ready(data_req_ready),
        .data_resp_valid(data_resp_valid),
        .data_resp_data(data_resp_data),
        .flush(flush),
        .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data),
        .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable),
        .starve_count(starve_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_write_address[7:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_read_address[7:0]];

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fetch_req_valid = 1'b0;
        fetch_req_addr  = 32'h0;
        data_req_valid  = 1'b0;
        data_req_write  = 1'b0;
        data_req_addr   = 32'h0;
        data_req_wdata  = 32'h0;
        flush           = 1'b0;
    endtask

    task automatic test_reset;
        rst             = 1'b0;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 32'h4;
        data_req_valid  = 1'b1;
        data_req_write  = 1'b1;
        data_req_addr   = 32'hF0;
        data_req_wdata  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (fetch_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: got fetch=%b data=%b expected 0 0", fetch_req_ready, data_req_ready);
            end
            checks++;
            if (mem_write_enable !== 1'b0) begin
                errors++;
                $display("FAIL reset_wen: got %b expected 0", mem_write_enable);
            end
            checks++;
            if (fetch_resp_valid !== 1'b0 || data_resp_valid !== 1'b0 || data_resp_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_resp: got fv=%b dv=%b dd=%h expected 0 0 0", fetch_resp_valid, data_resp_valid, data_resp_data);
            end
            checks++;
            if (starve_count !== 4'd0) begin
                errors++;
                $display("FAIL reset_starve: got %0d expected 0", starve_count);
            end
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (data_req_ready !== 1'b1 || fetch_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_grant: got data=%b fetch=%b expected 1 0", data_req_ready, fetch_req_ready);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fetch_only;
        for (int i = 0; i < 5; i++) begin
            fetch_req_valid = (i < 3);
            fetch_req_addr  = 32'(i);
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (fetch_req_ready !== 1'b1 || mem_read_address !== 32'(i)) begin
                    errors++;
                    $display("FAIL fetch_only_grant[%0d]: got ready=%b addr=%h expected 1 %h", i, fetch_req_ready, mem_read_address, i);
                end
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (fetch_resp_valid !== 1'b1 || fetch_resp_data !== 32'hA0 + 32'(i - 1)) begin
                    errors++;
                    $display("FAIL fetch_only_resp[%0d]: got v=%b d=%h expected 1 %h", i, fetch_resp_valid, fetch_resp_data, 32'hA0 + 32'(i - 1));
                end
            end
            if (i == 4) begin
                checks++;
                if (fetch_resp_valid !== 1'b0 || fetch_resp_data !== 32'hA2) begin
                    errors++;
                    $display("FAIL fetch_only_hold: got v=%b d=%h expected 0 a2", fetch_resp_valid, fetch_resp_data);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation;
        int cexp [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        for (int i = 0; i < 9; i++) begin
            fetch_req_valid = (i < 8);
            fetch_req_addr  = 32'h3;
            data_req_valid  = (i < 8);
            data_req_write  = 1'b0;
            data_req_addr   = 32'h20;
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if (data_req_ready !== ((i % 4) != 3) || fetch_req_ready !== ((i % 4) == 3)) begin
                    errors++;
                    $display("FAIL starve_order[%0d]: got data=%b fetch=%b expected data=%b", i, data_req_ready, fetch_req_ready, ((i % 4) != 3));
                end
            end
            checks++;
            if (starve_count !== 4'(cexp[i])) begin
                errors++;
                $display("FAIL starve_count[%0d]: got %0d expected %0d", i, starve_count, cexp[i]);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_store_load;
        data_req_valid = 1'b1;
        data_req_write = 1'b1;
        data_req_addr  = 32'h10;
        data_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (data_req_ready !== 1'b1 || mem_write_enable !== 1'b1 || mem_write_address !== 32'h10 || mem_write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_drive: got rdy=%b we=%b wa=%h wd=%h expected 1 1 10 deadbeef", data_req_ready, mem_write_enable, mem_write_address, mem_write_data);
        end
        next_cycle();
        data_req_write = 1'b0;
        data_req_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (data_resp_valid !== 1'b1 || data_resp_data !== 32'h0 || mem_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL store_ack: got v=%b d=%h we=%b expected 1 0 0", data_resp_valid, data_resp_data, mem_write_enable);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (data_resp_valid !== 1'b1 || data_resp_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_load: got v=%b d=%h expected 1 deadbeef", data_resp_valid, data_resp_data);
        end
        next_cycle();
    endtask

    task automatic test_flush;
        fetch_req_valid = 1'b1;
        fetch_req_addr  = 32'h5;
        @(negedge clk);
        checks++;
        if (fetch_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_grant: got %b expected 1", fetch_req_ready);
        end
        next_cycle();
        fetch_req_addr = 32'h6;
        flush          = 1'b1;
        data_req_valid = 1'b1;
        data_req_addr  = 32'h10;
        @(negedge clk);
        checks++;
        if (fetch_resp_valid !== 1'b0 || fetch_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_block: got rv=%b rdy=%b expected 0 0", fetch_resp_valid, fetch_req_ready);
        end
        checks++;
        if (data_req_ready !== 1'b1 || mem_read_address !== 32'h10) begin
            errors++;
            $display("FAIL flush_data_grant: got rdy=%b addr=%h expected 1 10", data_req_ready, mem_read_address);
        end
        next_cycle();
        flush          = 1'b0;
        data_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fetch_req_ready !== 1'b1 || data_resp_valid !== 1'b1 || data_resp_data !== 32'hDEAD_BEEF || starve_count !== 4'd0) begin
            errors++;
            $display("FAIL flush_resume: got frdy=%b dv=%b dd=%h sc=%0d expected 1 1 deadbeef 0", fetch_req_ready, data_resp_valid, data_resp_data, starve_count);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (fetch_resp_valid !== 1'b1 || fetch_resp_data !== 32'hB6) begin
            errors++;
            $display("FAIL flush_after_resp: got v=%b d=%h expected 1 b6", fetch_resp_valid, fetch_resp_data);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        data_req_valid = 1'b1;
        data_req_write = 1'b0;
        data_req_addr  = 32'h20;
        @(negedge clk);
        checks++;
        if (data_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_grant: got %b expected 1", data_req_ready);
        end
        #4;
        rst            = 1'b0;
        data_req_write = 1'b1;
        data_req_wdata = 32'h5555_AAAA;
        next_cycle();
        @(negedge clk);
        checks++;
        if (data_resp_valid !== 1'b0 || data_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_resp: got v=%b d=%h expected 0 0", data_resp_valid, data_resp_data);
        end
        checks++;
        if (mem_write_enable !== 1'b0 || data_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_wen: got we=%b rdy=%b expected 0 0", mem_write_enable, data_req_ready);
        end
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'hA0;
        mem[1] = 32'hA1;
        mem[2] = 32'hA2;
        mem[5] = 32'hB5;
        mem[6] = 32'hB6;
        mem[32] = 32'hC0FFEE;
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_fetch_only();
        test_starvation();
        test_store_load();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
